// File: rtl/spi_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_loader_if
// Purpose  : Bundles the SPI byte stream and the frame-buffer write port
//            used by spi_frame_loader.
// Ports    : rx_data/rx_valid/ss_active - byte stream from the SPI slave
//            ready                      - frame buffer can take a transaction
//            wdata/wrow/wcol/wen        - frame-buffer write port
//            swap/brightness/status     - commit pulse and register readback
//            modport slave  : decoder side
//            modport master : byte source / frame buffer side
// Revision : 1.0 - initial release
// ============================================================================
interface spi_frame_loader_if #(
  parameter int SEGMENTS = 1,
  parameter int ROWS     = 8,
  parameter int COLUMNS  = 32,
  parameter int CHANNELS = 3,
  parameter int BITWIDTH = 8
);
  localparam int c_W  = SEGMENTS * CHANNELS * BITWIDTH;
  localparam int c_RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            ss_active;
  logic            ready;
  logic [c_W-1:0]  wdata;
  logic [c_RW-1:0] wrow;
  logic [c_CW-1:0] wcol;
  logic            wen;
  logic            swap;
  logic [7:0]      brightness;
  logic [7:0]      status;

  modport slave (
    input  rx_data, rx_valid, ss_active, ready,
    output wdata, wrow, wcol, wen, swap, brightness, status
  );

  modport master (
    output rx_data, rx_valid, ss_active, ready,
    input  wdata, wrow, wcol, wen, swap, brightness, status
  );
endinterface
`default_nettype wire

// File: rtl/spi_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_loader
// Purpose  : Decodes SPI command bytes and streams pixel words into the
//            display frame buffer (full frame or single row), plus buffer
//            commit, brightness register and sticky status/error flags.
// Ports    : clk - system clock
//            rst - synchronous reset, active low
//            bus - spi_frame_loader_if.slave (byte stream in, write port out)
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_loader #(
  parameter int SEGMENTS = 1,
  parameter int ROWS     = 8,
  parameter int COLUMNS  = 32,
  parameter int CHANNELS = 3,
  parameter int BITWIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  spi_frame_loader_if.slave bus
);
  localparam int c_W  = SEGMENTS * CHANNELS * BITWIDTH;
  localparam int c_RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int c_HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_SW = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_ROW_ADDR = 3'd1;
  localparam logic [2:0] c_LOAD     = 3'd2;
  localparam logic [2:0] c_REG      = 3'd3;
  localparam logic [2:0] c_COMMIT   = 3'd4;
  localparam logic [2:0] c_DISCARD  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic            armed_q, armed_d;
  logic [c_RW-1:0] row_q, row_d, last_row_q, last_row_d;
  logic [c_CW-1:0] col_q, col_d;
  logic [c_HW-1:0] ch_q, ch_d;
  logic [c_SW-1:0] seg_q, seg_d;
  logic [c_W-1:0]  wdata_q, wdata_d;
  logic [c_RW-1:0] wrow_q, wrow_d;
  logic [c_CW-1:0] wcol_q, wcol_d;
  logic            wen_q, wen_d, swap_q, swap_d;
  logic [7:0]      brightness_q, brightness_d;
  logic            err_cmd_q, err_cmd_d, err_row_q, err_row_d;
  logic            err_short_q, err_short_d, err_busy_q, err_busy_d;
  logic            frame_done_q, frame_done_d;

  logic            w_cmd, w_end, w_word_last, w_limit, w_row_ok;
  logic [c_W-1:0]  w_shifted;

  // armed_q blocks command decode until chip-select has been seen low, so a
  // transaction interrupted by reset is ignored until it finishes.
  assign w_cmd       = (state_q == c_IDLE) && armed_q && bus.ss_active && bus.rx_valid;
  assign w_end       = (state_q != c_IDLE) && !bus.ss_active;
  assign w_word_last = (ch_q == c_HW'(CHANNELS - 1)) && (seg_q == c_SW'(SEGMENTS - 1));
  assign w_limit     = (state_q == c_LOAD) && bus.rx_valid && w_word_last &&
                       (col_q == c_CW'(COLUMNS - 1)) && (row_q == last_row_q);
  assign w_row_ok    = {24'd0, bus.rx_data} < 32'(ROWS);

  generate
    if (c_W > BITWIDTH) begin : g_shift_wide
      assign w_shifted = {wdata_q[c_W-BITWIDTH-1:0], bus.rx_data[BITWIDTH-1:0]};
    end else begin : g_shift_narrow
      assign w_shifted = bus.rx_data[BITWIDTH-1:0];
    end
  endgenerate

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= c_IDLE;
      armed_q      <= 1'b0;
      row_q        <= '0;
      last_row_q   <= '0;
      col_q        <= '0;
      ch_q         <= '0;
      seg_q        <= '0;
      wdata_q      <= '0;
      wrow_q       <= '0;
      wcol_q       <= '0;
      wen_q        <= 1'b0;
      swap_q       <= 1'b0;
      brightness_q <= 8'hFF;
      err_cmd_q    <= 1'b0;
      err_row_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_busy_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      row_q        <= row_d;
      last_row_q   <= last_row_d;
      col_q        <= col_d;
      ch_q         <= ch_d;
      seg_q        <= seg_d;
      wdata_q      <= wdata_d;
      wrow_q       <= wrow_d;
      wcol_q       <= wcol_d;
      wen_q        <= wen_d;
      swap_q       <= swap_d;
      brightness_q <= brightness_d;
      err_cmd_q    <= err_cmd_d;
      err_row_q    <= err_row_d;
      err_short_q  <= err_short_d;
      err_busy_q   <= err_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_cmd) begin
          if (!bus.ready) begin
            state_d = c_DISCARD;
          end else begin
            case (bus.rx_data)
              8'hF0:   state_d = c_LOAD;
              8'hF1:   state_d = c_ROW_ADDR;
              8'h20:   state_d = c_REG;
              8'h10:   state_d = c_COMMIT;
              default: state_d = c_DISCARD;
            endcase
          end
        end
      end
      c_ROW_ADDR: if (bus.rx_valid) state_d = w_row_ok ? c_LOAD : c_DISCARD;
      c_LOAD:     if (w_limit) state_d = c_DISCARD;
      c_REG:      if (bus.rx_valid) state_d = c_DISCARD;
      default:    state_d = state_q;
    endcase
    // End of transaction overrides everything; the byte of this cycle has
    // already been accounted for by the output process.
    if (w_end) state_d = c_IDLE;
  end

  // Output / datapath logic
  always_comb begin
    armed_d      = armed_q | ~bus.ss_active;
    row_d        = row_q;
    last_row_d   = last_row_q;
    col_d        = col_q;
    ch_d         = ch_q;
    seg_d        = seg_q;
    wdata_d      = wdata_q;
    wrow_d       = wrow_q;
    wcol_d       = wcol_q;
    wen_d        = 1'b0;
    swap_d       = 1'b0;
    brightness_d = brightness_q;
    err_cmd_d    = err_cmd_q;
    err_row_d    = err_row_q;
    err_short_d  = err_short_q;
    err_busy_d   = err_busy_q;
    frame_done_d = frame_done_q;

    case (state_q)
      c_IDLE: begin
        if (w_cmd) begin
          if (!bus.ready) begin
            err_busy_d = 1'b1;
          end else begin
            case (bus.rx_data)
              8'hF0: begin
                row_d      = '0;
                col_d      = '0;
                ch_d       = '0;
                seg_d      = '0;
                last_row_d = c_RW'(ROWS - 1);
              end
              8'hF1, 8'h20, 8'h10: ;
              8'h30: begin
                err_cmd_d    = 1'b0;
                err_row_d    = 1'b0;
                err_short_d  = 1'b0;
                err_busy_d   = 1'b0;
                frame_done_d = 1'b0;
              end
              default: err_cmd_d = 1'b1;
            endcase
          end
        end
      end
      c_ROW_ADDR: begin
        if (bus.rx_valid) begin
          if (w_row_ok) begin
            row_d      = bus.rx_data[c_RW-1:0];
            last_row_d = bus.rx_data[c_RW-1:0];
            col_d      = '0;
            ch_d       = '0;
            seg_d      = '0;
          end else begin
            err_row_d = 1'b1;
          end
        end
      end
      c_LOAD: begin
        if (bus.rx_valid) begin
          wdata_d = w_shifted;
          if (w_word_last) begin
            ch_d   = '0;
            seg_d  = '0;
            wen_d  = 1'b1;
            wrow_d = row_q;
            wcol_d = col_q;
            if (w_limit) begin
              frame_done_d = 1'b1;
            end else if (col_q == c_CW'(COLUMNS - 1)) begin
              col_d = '0;
              row_d = row_q + c_RW'(1);
            end else begin
              col_d = col_q + c_CW'(1);
            end
          end else if (ch_q == c_HW'(CHANNELS - 1)) begin
            ch_d  = '0;
            seg_d = seg_q + c_SW'(1);
          end else begin
            ch_d = ch_q + c_HW'(1);
          end
        end
      end
      c_REG: if (bus.rx_valid) brightness_d = bus.rx_data;
      default: ;
    endcase

    if (w_end) begin
      if (state_q == c_COMMIT) swap_d = 1'b1;
      if ((state_q == c_LOAD) && !w_limit) err_short_d = 1'b1;
      row_d = '0;
      col_d = '0;
      ch_d  = '0;
      seg_d = '0;
    end
  end

  assign bus.wdata      = wdata_q;
  assign bus.wrow       = wrow_q;
  assign bus.wcol       = wcol_q;
  assign bus.wen        = wen_q;
  assign bus.swap       = swap_q;
  assign bus.brightness = brightness_q;
  assign bus.status     = {err_cmd_q, err_row_q, err_short_q, err_busy_q,
                           2'b00, (state_q != c_IDLE), frame_done_q};
endmodule
`default_nettype wire

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Parametrised successor to the display SPI command decoder. Consumes a byte stream from the SPI slave and decodes commands.
- Streams pixel words into the display frame buffer, in two modes: full frame or single addressed row.
- Also handles buffer-swap (commit), brightness register and status/error readback.
- Sits between spi_slave and the frame-buffer write port. Generalised over segments, channels and colour bit width.

Parameters:
- SEGMENTS, 1, panels chained per column word
- ROWS, 8, addressable rows (>=2)
- COLUMNS, 32, columns per row (>=2)
- CHANNELS, 3, colour channels per pixel (1..4)
- BITWIDTH, 8, bits per channel (1..8); the low BITWIDTH bits of each byte are used

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low (0 = reset)
- rx_data  in  8  received SPI byte
- rx_valid  in  1  one-cycle strobe: rx_data valid
- ss_active  in  1  high while SPI chip-select is asserted
- ready  in  1  frame buffer can accept a new transaction
- wdata  out  SEGMENTS*CHANNELS*BITWIDTH  pixel word
- wrow  out  max(1,$clog2(ROWS))  write row
- wcol  out  max(1,$clog2(COLUMNS))  write column
- wen  out  1  one-cycle write strobe
- swap  out  1  one-cycle commit pulse
- brightness  out  8  global brightness register
- status  out  8  {err_cmd, err_row, err_short, err_busy, 2'b0, busy, frame_done}

Behaviour:
- Reset (rst=0 at posedge) values:
  - wdata=0, wrow=0, wcol=0, wen=0, swap=0
  - brightness=8'hFF, status=0
  - state=IDLE; all counters 0
- The first rx_valid byte after ss_active rises is the command byte. The decoder acts only in state IDLE.
- If ready=0 when the command byte arrives: set err_busy and go to DISCARD.
- Transaction end is ss_active=0. From any state except IDLE it returns to IDLE on the next cycle, after any end action listed below.
- States: IDLE, ROW_ADDR, LOAD, REG, COMMIT, DISCARD.
- Command codes:
  - 8'hF0 (full frame): row=0, col=0, limit = all rows; go to LOAD.
  - 8'hF1 (single row): go to ROW_ADDR. The next byte is the row index.
    - Index >= ROWS: set err_row, go to DISCARD.
    - Otherwise row=index, col=0, limit = that row only; go to LOAD.
  - 8'h20: go to REG. The next byte loads brightness; then go to DISCARD.
  - 8'h10: go to COMMIT. swap pulses for exactly one cycle, on the cycle ss_active=0 is seen. Bytes received meanwhile are ignored.
  - 8'h30: clear all four error flags and frame_done; go to DISCARD.
  - Any other value: set err_cmd; go to DISCARD.
- LOAD byte handling:
  - Each byte does wdata <= {wdata[W-BITWIDTH-1:0], rx_data[BITWIDTH-1:0]}.
  - Channel and segment counters advance, channel fastest.
  - On the last byte of a word (channel=CHANNELS-1, segment=SEGMENTS-1), on the next clock edge: wen=1 for one cycle, with wrow/wcol holding that word's address and wdata holding the complete word.
  - col then increments. At COLUMNS-1 it wraps to 0 and row increments.
  - Frame mode: after word (ROWS-1, COLUMNS-1) set frame_done and go to DISCARD; extra bytes are ignored.
  - Row mode: after column COLUMNS-1, set frame_done and go to DISCARD.
- Latency: wen is asserted exactly 1 cycle after the rx_valid of the word's last byte.
- ss_active falling in LOAD before the limit is reached:
  - Set err_short.
  - A partial word is never written; no wen.
  - Counters reset at IDLE.
- Simultaneous rx_valid and ss_active=0: the byte is processed first, then the end action.
- busy=1 whenever state != IDLE.
- Error flags are sticky until cmd 8'h30 or reset.
- Reset mid-transaction: everything returns to reset values on the next edge. No wen or swap is emitted. Bytes of the interrupted transaction are ignored until ss_active falls.

Test Plan:
- SEGMENTS=1, CHANNELS=3, BITWIDTH=8, ROWS=2, COLUMNS=2. Send F0 then 12 bytes 01..0C:
  - Four wen pulses at (r,c) = (0,0), (0,1), (1,0), (1,1), with wdata 010203, 040506, 070809, 0A0B0C.
  - frame_done=1; a 13th byte produces no wen.
- Send F1 01, then 6 bytes AA..FF (COLUMNS=2):
  - wen at (1,0) wdata=AABBCC and at (1,1) wdata=DDEEFF.
  - F1 05 instead: err_row=1, no wen.
- Send F0, then 4 bytes, then drop ss_active:
  - One wen at (0,0); err_short=1; busy=0 within 1 cycle.
  - The next F0 transaction restarts at (0,0).
- Send 10, then drop ss_active: swap high exactly 1 cycle. Send 20 40: brightness=8'h40. Send 77: err_cmd=1. Send 30: all error bits 0.
- Hold ready=0 and send F0 plus 6 bytes: err_busy=1, no wen, no change to wdata.
- Drive rst=0 for 1 cycle mid-LOAD: all outputs return to reset values, brightness=FF, no spurious wen or swap.
